// File: rtl/frame_480_unpacker_pkg.sv
//==============================================================================
// Module   : frame_pkg
// Purpose  : Shared constants and state type for the 480-byte frame unpacker.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package frame_pkg;

    localparam int WORD_W  = 16;
    localparam int N_WORDS = 240;
    localparam int FRAME_W = WORD_W * N_WORDS;
    localparam int DROP_W  = 8;
    localparam int IDX_W   = $clog2(N_WORDS);

    localparam logic [WORD_W-1:0] CSUM_OK = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        REPORT = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/frame_480_unpacker_oc_add16.sv
//==============================================================================
// Module   : oc_add16
// Purpose  : Combinational 16-bit ones-complement adder with end-around carry.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module oc_add16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    output logic [15:0] o_sum
);

    logic [16:0] w_raw;

    assign w_raw = {1'b0, i_a} + {1'b0, i_b};
    // Carry out of bit 15 wraps back into bit 0; cannot overflow a second time.
    assign o_sum = w_raw[15:0] + {15'd0, w_raw[16]};

endmodule

`default_nettype wire

// File: rtl/frame_480_unpacker.sv
//==============================================================================
// Module   : frame_480_unpacker
// Purpose  : Captures a 240-word frame, replays it as a valid/ready word stream,
//            reports its ones-complement checksum and counts dropped frames.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module frame_480_unpacker
    import frame_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic [WORD_W-1:0]  word_out,
    output logic               word_valid,
    input  logic               word_ready,
    output logic               word_first,
    output logic               word_last,
    output logic               sum_valid,
    output logic               sum_ok,
    output logic [WORD_W-1:0]  sum_value,
    output logic [DROP_W-1:0]  drop_cnt
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [FRAME_W-1:0] r_buf;
    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_sum;
    logic [WORD_W-1:0]  r_sum_value;
    logic               r_sum_ok;
    logic [DROP_W-1:0]  r_drop;

    logic [WORD_W-1:0]  w_head;
    logic [WORD_W-1:0]  w_sum_nxt;
    logic               w_capture;
    logic               w_accept;
    logic               w_is_last;
    logic               w_drop;

    assign w_head    = r_buf[FRAME_W-1 -: WORD_W];
    assign w_capture = (r_state == IDLE) && frame_valid;
    assign w_accept  = (r_state == SEND) && word_ready;
    assign w_is_last = (r_idx == IDX_W'(N_WORDS - 1));
    assign w_drop    = (r_state != IDLE) && frame_valid;

    oc_add16 u_csum (
        .i_a   (r_sum),
        .i_b   (w_head),
        .o_sum (w_sum_nxt)
    );

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (frame_valid) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_accept && w_is_last) begin
                    w_state_nxt = REPORT;
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // FSM: state-decoded outputs
    //--------------------------------------------------------------------------
    always_comb begin
        frame_ready = 1'b0;
        word_valid  = 1'b0;
        word_first  = 1'b0;
        word_last   = 1'b0;
        sum_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                frame_ready = 1'b1;
            end
            SEND: begin
                word_valid = 1'b1;
                word_first = (r_idx == '0);
                word_last  = w_is_last;
            end
            REPORT: begin
                sum_valid = 1'b1;
            end
            default: begin
                frame_ready = 1'b0;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Frame buffer, word index and running checksum
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_idx <= '0;
            r_sum <= '0;
        end else if (w_capture) begin
            r_buf <= frame_in;
            r_idx <= '0;
            r_sum <= '0;
        end else if (w_accept) begin
            r_buf <= {r_buf[FRAME_W-WORD_W-1:0], {WORD_W{1'b0}}};
            r_idx <= r_idx + IDX_W'(1);
            r_sum <= w_sum_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // Checksum report: latched as the last word is accepted so it is visible
    // during the REPORT cycle, then held until the next frame completes.
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_value <= '0;
            r_sum_ok    <= 1'b0;
        end else if (w_accept && w_is_last) begin
            r_sum_value <= w_sum_nxt;
            r_sum_ok    <= (w_sum_nxt == CSUM_OK);
        end
    end

    //--------------------------------------------------------------------------
    // Saturating drop counter
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
            r_drop <= r_drop + DROP_W'(1);
        end
    end

    assign word_out  = w_head;
    assign sum_value = r_sum_value;
    assign sum_ok    = r_sum_ok;
    assign drop_cnt  = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_frame_480_unpacker.sv
//==============================================================================
// Module   : tb_frame_480_unpacker
// Purpose  : Self-checking bench for frame_480_unpacker (model + directed tests).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_frame_480_unpacker;
    import frame_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [FRAME_W-1:0] frame_in;
    logic               frame_valid;
    logic               frame_ready;
    logic [WORD_W-1:0]  word_out;
    logic               word_valid;
    logic               word_ready;
    logic               word_first;
    logic               word_last;
    logic               sum_valid;
    logic               sum_ok;
    logic [WORD_W-1:0]  sum_value;
    logic [DROP_W-1:0]  drop_cnt;

    frame_480_unpacker dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .word_out    (word_out),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .word_first  (word_first),
        .word_last   (word_last),
        .sum_valid   (sum_valid),
        .sum_ok      (sum_ok),
        .sum_value   (sum_value),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a phase (0 idle, 1 streaming, 2 reporting), the
    // captured words, a read position and the checksum of the whole frame.
    logic [WORD_W-1:0] m_words [N_WORDS];
    int                m_phase = 0;
    int                m_old   = 0;
    int                m_idx   = 0;
    int                m_drop  = 0;
    logic [15:0]       m_pend  = '0;
    logic [15:0]       m_rep_val = '0;
    logic              m_rep_ok  = 1'b0;

    function automatic logic [15:0] ocsum_of(input logic [FRAME_W-1:0] f);
        longint t;
        t = 0;
        for (int i = 0; i < N_WORDS; i++) t += longint'(f[FRAME_W-1-WORD_W*i -: WORD_W]);
        while ((t >> 16) != 0) t = (t & 64'hFFFF) + (t >> 16);
        return 16'(t);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase   = 0;
            m_idx     = 0;
            m_drop    = 0;
            m_rep_val = '0;
            m_rep_ok  = 1'b0;
        end else begin
            m_old = m_phase;
            if (frame_valid) begin
                if (m_old == 0) begin
                    for (int i = 0; i < N_WORDS; i++) m_words[i] = frame_in[FRAME_W-1-WORD_W*i -: WORD_W];
                    m_pend  = ocsum_of(frame_in);
                    m_idx   = 0;
                    m_phase = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            if (m_old == 1 && word_ready) begin
                if (m_idx == N_WORDS - 1) begin
                    m_phase   = 2;
                    m_rep_val = m_pend;
                    m_rep_ok  = (m_pend == 16'hFFFF);
                end else begin
                    m_idx++;
                end
            end
            if (m_old == 2) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("frame_ready", 32'(frame_ready), 32'(m_phase == 0));
            check("word_valid",  32'(word_valid),  32'(m_phase == 1));
            check("word_first",  32'(word_first),  32'(m_phase == 1 && m_idx == 0));
            check("word_last",   32'(word_last),   32'(m_phase == 1 && m_idx == N_WORDS - 1));
            if (m_phase == 1) check("word_out", 32'(word_out), 32'(m_words[m_idx]));
            check("sum_valid",   32'(sum_valid),   32'(m_phase == 2));
            check("sum_value",   32'(sum_value),   32'(m_rep_val));
            check("sum_ok",      32'(sum_ok),      32'(m_rep_ok));
            check("drop_cnt",    32'(drop_cnt),    32'(m_drop));
        end
    end

    logic [WORD_W-1:0] fw [N_WORDS];

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_frame();
        for (int i = 0; i < N_WORDS; i++) frame_in[FRAME_W-1-WORD_W*i -: WORD_W] = fw[i];
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (!sum_valid && n < 700) begin
            @(negedge clk);
            n++;
        end
        check({tag, " sum_valid seen"}, 32'(sum_valid), 32'd1);
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;
        int n_send;
        int seen;

        frame_valid = 1'b0;
        word_ready  = 1'b1;
        frame_in    = '0;
        rst_n       = 1'b1;
        #1 rst_n    = 1'b0;
        #1 chk_en   = 1'b1;
        #1;
        check("rst frame_ready", 32'(frame_ready), 32'd1);
        check("rst word_valid",  32'(word_valid),  32'd0);
        check("rst word_out",    32'(word_out),    32'd0);
        check("rst sum_valid",   32'(sum_valid),   32'd0);
        check("rst sum_ok",      32'(sum_ok),      32'd0);
        check("rst sum_value",   32'(sum_value),   32'd0);
        check("rst drop_cnt",    32'(drop_cnt),    32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Counting frame whose last word closes the checksum to FFFF
        for (int i = 0; i < N_WORDS - 1; i++) fw[i] = 16'(i + 1);
        fw[N_WORDS-1] = 16'h8FF7;
        check("model csum of counting frame", 32'(ocsum_of({frame_in[FRAME_W-1:WORD_W], 16'h0})), 32'd0);
        load_frame();
        check("model csum of counting frame", 32'(ocsum_of(frame_in)), 32'hFFFF);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("t1 word0 valid", 32'(word_valid), 32'd1);
        check("t1 word0 value", 32'(word_out),   32'h0001);
        check("t1 word0 first", 32'(word_first), 32'd1);
        n = 1;
        while (!sum_valid && n < 400) begin
            step();
            n++;
        end
        check("t1 sum latency", 32'(n), 32'd241);
        check("t1 sum_value", 32'(sum_value), 32'hFFFF);
        check("t1 sum_ok",    32'(sum_ok),    32'd1);
        step();
        check("t1 frame_ready after report", 32'(frame_ready), 32'd1);

        // All-zero frame
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'h0000;
        load_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        drain("t2");
        check("t2 sum_value", 32'(sum_value), 32'h0000);
        check("t2 sum_ok",    32'(sum_ok),    32'd0);

        // All-FFFF frame under alternating backpressure, first SEND cycle stalled
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'hFFFF;
        load_frame();
        frame_valid = 1'b1;
        word_ready  = 1'b0;
        step();
        frame_valid = 1'b0;
        k = 0;
        n_send = 0;
        while (k < 700) begin
            @(negedge clk);
            if (sum_valid) break;
            if (word_valid) n_send++;
            step();
            k++;
            word_ready = k[0];
        end
        check("t3 send cycles", 32'(n_send),    32'd480);
        check("t3 sum_value",   32'(sum_value), 32'hFFFF);
        check("t3 sum_ok",      32'(sum_ok),    32'd1);
        word_ready = 1'b1;
        step();

        // Drops 10 cycles after capture and on the REPORT cycle
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'(16'h3000 + i * 3);
        load_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        repeat (9) step();
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'hBEEF;
        load_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        n = 0;
        while (!sum_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("t4 report reached", 32'(sum_valid), 32'd1);
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("t4 drop_cnt",     32'(drop_cnt),    32'd2);
        check("t4 frame_ready",  32'(frame_ready), 32'd1);
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'(16'h5A00 + i);
        load_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("t4 next word0 valid", 32'(word_valid), 32'd1);
        check("t4 next word0 value", 32'(word_out),   32'h5A00);
        drain("t4");

        // Reset asserted while word 100 is on the output
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'(16'h1000 + i);
        load_frame();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        n = 0;
        while (word_out != 16'h1064 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t5 reached word 100", 32'(word_out), 32'h1064);
        #2 rst_n = 1'b0;
        #1;
        check("t5 async word_valid",  32'(word_valid),  32'd0);
        check("t5 async frame_ready", 32'(frame_ready), 32'd1);
        check("t5 async word_out",    32'(word_out),    32'd0);
        check("t5 async word_first",  32'(word_first),  32'd0);
        check("t5 async sum_value",   32'(sum_value),   32'd0);
        check("t5 async drop_cnt",    32'(drop_cnt),    32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (sum_valid) seen++;
        end
        check("t5 no sum_valid after reset", 32'(seen), 32'd0);
        step();
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check("t5 restart word0 value", 32'(word_out),   32'h1000);
        check("t5 restart word0 first", 32'(word_first), 32'd1);
        drain("t5");

        // Drop counter saturation while the stream is stalled
        for (int i = 0; i < N_WORDS; i++) fw[i] = 16'(i * 7);
        load_frame();
        word_ready  = 1'b0;
        frame_valid = 1'b1;
        step();
        repeat (300) step();
        frame_valid = 1'b0;
        step();
        check("t6 drop_cnt saturated", 32'(drop_cnt), 32'd255);
        word_ready = 1'b1;
        drain("t6");
        check("t6 drop_cnt held", 32'(drop_cnt), 32'd255);

        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_480_unpacker.md
Name: frame_480_unpacker

Overview:
- Downstream stage of the 2-byte-to-480-byte serial-to-parallel collector.
- Captures one completed 3840-bit frame (240 x 16-bit words) and replays it as a 16-bit word stream under a valid/ready handshake.
- Accumulates a 16-bit ones-complement checksum over the frame and reports a pass/fail flag at end of frame.
- Counts frames offered while busy, which are dropped.

Parameters:
- WORD_W, 16, word width in bits.
- N_WORDS, 240, words per frame.
- FRAME_W, WORD_W*N_WORDS (3840), frame width in bits.
- DROP_W, 8, drop counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- frame_in  in  FRAME_W  completed frame; oldest word in [FRAME_W-1 -: WORD_W].
- frame_valid  in  1  frame_in valid this cycle.
- frame_ready  out  1  block idle, can capture a frame.
- word_out  out  WORD_W  current word.
- word_valid  out  1  word_out valid.
- word_ready  in  1  consumer accepts word_out.
- word_first  out  1  word_out is word 0 (qualified by word_valid).
- word_last  out  1  word_out is word N_WORDS-1 (qualified by word_valid).
- sum_valid  out  1  one-cycle pulse, checksum result available.
- sum_ok  out  1  final checksum == 16'hFFFF; held until next report.
- sum_value  out  WORD_W  final ones-complement sum; held until next report.
- drop_cnt  out  DROP_W  frames dropped while busy; saturating.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; frame_ready=1.
  - word_valid, word_first, word_last, sum_valid, sum_ok = 0.
  - word_out, sum_value, drop_cnt = 0; internal buffer, index and sum = 0.
- States:
  - IDLE: frame_ready=1, word_valid=0. If frame_valid: copy frame_in into buffer, index=0, sum=0, go to SEND.
  - SEND: frame_ready=0, word_valid=1, word_out = buffer[FRAME_W-1 -: WORD_W].
    - On word_valid && word_ready: shift buffer left by WORD_W, sum <= oc_add(sum, word_out), index++.
    - If the accepted word had index == N_WORDS-1, go to REPORT.
  - REPORT: for exactly one cycle, sum_valid=1 and sum_value/sum_ok are registered from the final sum; frame_ready=0, word_valid=0. Next state is IDLE.
- Ones-complement add: s = {1'b0,a} + {1'b0,b} (17 bits); result = s[15:0] + s[16]. Result is always 16 bits; FFFF + 0000 = FFFF.
- Latency:
  - frame_valid in IDLE at cycle T gives word_valid=1 with word 0 at T+1.
  - Last word accepted at cycle L gives sum_valid at L+1 and frame_ready=1 at L+2.
  - Minimum frame period is N_WORDS+2 cycles.
- word_first=1 when index==0; word_last=1 when index==N_WORDS-1. Both are 0 outside SEND.
- Backpressure: while word_ready=0, word_out, word_first and word_last stay stable and index does not advance. word_valid never drops mid-frame.
- Drops: frame_valid while state != IDLE (including REPORT) means the frame is ignored and drop_cnt increments. drop_cnt saturates at 2^DROP_W-1 and is cleared only by reset.
- Reset mid-frame: the frame is discarded and no sum_valid is produced. After reset is released, behaviour is the same as from power-up.
- sum_ok and sum_value keep their last reported values through later frames until the next REPORT.

Decomposition:
- Shared package frame_pkg:
  - Constants WORD_W, N_WORDS, FRAME_W.
  - State enum {IDLE, SEND, REPORT}.
  - Checksum pass constant CSUM_OK = 16'hFFFF.
- One sub-module, oc_add16: combinational 16-bit ones-complement adder with end-around carry, reused by the checksum generator upstream.
- Top level contains the FSM, buffer shift register, index counter and drop counter.

Test Plan:
- Reset, then frame words 0x0001..0x00EF plus last word = ~(ones-complement sum of the first 239), frame_valid one cycle, word_ready=1 -> 240 words in order 0x0001 first; word_first on word 0, word_last on word 239; sum_valid pulse at L+1 with sum_ok=1, sum_value=0xFFFF.
- All-zero frame -> 240 words of 0x0000, sum_valid with sum_ok=0, sum_value=0x0000.
- Frame with every word 0xFFFF, word_ready toggling 1/0 each cycle -> word_out stable while stalled; 480 cycles of SEND; sum_value=0xFFFF, sum_ok=1.
- Second frame_valid 10 cycles after the first capture, and another exactly on the REPORT cycle -> both ignored, drop_cnt=2, output stream unchanged. Next frame_valid in IDLE is accepted, with word 0 one cycle later.
- rst_n pulsed low at word index 100 -> outputs drop to their reset values asynchronously; no sum_valid; drop_cnt=0. A new frame afterwards streams from word 0.
- 300 frame_valid pulses while SEND is held (word_ready=0) -> drop_cnt saturates at 255.
